ser_ctrl: RTL
=============

# ser_ctrl

Controller and two-requester arbiter for the 32-to-1 bit serializer. It accepts 32-bit words from two independent producers over valid/ready handshakes and arbitrates between them. It presents the granted word to the serializer and asserts the serializer's read enable for exactly 32 cycles per word. It also keeps a shadow of the serializer's unresettable bit counter, so word boundaries stay aligned across resets.

## Interface

- GAP_CYCLES, default 0: extra idle cycles inserted after each word before the next grant (0..15).
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0_valid  in  1  requester 0 has a word.
- req0_data  in  32  requester 0 word; bit 0 is transmitted first.
- req0_ready  out  1  requester 0 word accepted on this edge if req0_valid.
- req1_valid / req1_data / req1_ready: same as above, for requester 1.
- ser_rd_en  out  1  serializer read enable.
- ser_word  out  32  word presented to the serializer data input.
- bit_idx  out  5  shadow of the serializer bit counter.
- grant_id  out  1  requester whose word is being or was last shifted.
- word_done  out  1  one-cycle pulse during the final (bit 31) shift cycle.
- busy  out  1  high in every state except IDLE.

## Operation

- **FLUSH (reset state).**
  - ser_rd_en = (align_cnt != 0) and ser_word = 0.
  - Moves to IDLE on the edge where align_cnt == 0 is observed.
  - If align_cnt is already 0, FLUSH lasts exactly one cycle.
- **IDLE.**
  - Arbitration is round-robin. Priority goes to the requester not named by grant_id.
  - req_ready is combinational: asserted only for the winning requester, only while valid is high, and only in IDLE.
  - On the accepting edge: the word is latched into ser_word, grant_id is updated, and the state moves to SHIFT.
  - If neither requester is valid, the block stays in IDLE and both ready outputs stay low.
- **SHIFT.**
  - ser_rd_en = 1 for exactly 32 consecutive cycles.
  - ser_word is held stable for the whole word.
  - word_done = 1 when align_cnt == 31.
  - On that edge: to GAP if GAP_CYCLES > 0, otherwise to IDLE.
- **GAP.**
  - ser_rd_en = 0.
  - A 4-bit down-counter is loaded with GAP_CYCLES on entry. The block moves to IDLE when the counter reaches 1.
- **align_cnt (5 bits).**
  - Has initial value 0 and is deliberately excluded from reset, exactly matching the serializer's own counter.
  - Increments modulo 32 on every edge where ser_rd_en = 1. Wrap from 31 to 0 is the word boundary.
  - bit_idx = align_cnt.
- A word is never accepted unless align_cnt == 0.
- The block is the sole driver of the serializer read enable.
- Requester words are never dropped or duplicated. Each accepted handshake produces exactly one 32-cycle SHIFT.

## Timing

- **Reset values** (all apply asynchronously while rst = 1):
  - Registered state: state = FLUSH, ser_word = 0, grant_id = 1 (so requester 0 wins first), gap counter = 0.
  - Outputs: ser_rd_en = 0, word_done = 0, req0_ready = req1_ready = 0, busy = 1.
  - bit_idx holds its value (align_cnt is not reset).
- **Reset mid-word.** ser_rd_en drops immediately. After release, FLUSH issues 32 − align_cnt enable cycles with ser_word = 0, which realigns the serializer. The interrupted word is lost and not retried.
- **Latency.** Accept edge N gives ser_rd_en high for cycles N+1 .. N+32. Serialized bit k appears in cycle N+1+k, and word_done is in cycle N+32.
- **Throughput.** One word per 33 + GAP_CYCLES cycles, because IDLE always costs one cycle between words.
- **Simultaneous valid in IDLE.** The requester other than grant_id wins, so the two requesters strictly alternate.
- **Handshake rules.**
  - valid may drop before ready without penalty.
  - Data is sampled only on the accepting edge, so requesters may change req_data freely after acceptance.

## Configuration

- SER_CTRL_FIXED_PRIO_EN
  - Defined: requester 0 always wins when both are valid. grant_id still reports the last grant, and its reset value is unchanged.
  - Undefined (default): round-robin as described in Operation.

## Test plan

- **Power-up.** Pulse rst for 3 cycles with the shadow counter at 0 → FLUSH lasts 1 cycle and no ser_rd_en pulse occurs. Then drive req0_valid with 0xA5A5_0F0F → ser_rd_en high for exactly 32 cycles, the serializer output equals bits 0..31 of 0xA5A5_0F0F in order, and word_done occurs in the 32nd cycle.
- **Contention.** Hold both valids high with req0 = 0x0000_0001 and req1 = 0x8000_0000 for 4 words → grants alternate 0,1,0,1. With SER_CTRL_FIXED_PRIO_EN defined, the grants are 0,0,0,0.
- **Gap.** Set GAP_CYCLES = 3 with back-to-back req0 words → accepting edges are 36 cycles apart and ser_rd_en is low for 4 cycles between words.
- **Mid-word reset.** Assert rst when bit_idx = 11 → ser_rd_en is 0 during reset. After release, FLUSH drives ser_rd_en with ser_word = 0 for 21 cycles until bit_idx wraps to 0. The next word 0xDEAD_BEEF then serializes bit-aligned starting at bit 0.
- **Idle and late requests.** Keep both valids low for 50 cycles → block stays in IDLE, ready outputs stay 0 and bit_idx stays constant. Then raise req1_valid for one cycle only → the word is accepted that cycle, req1_ready is high exactly once, and no duplicate word follows.

Source files
------------

// File: rtl/ser_ctrl.sv
// Controller and two-requester arbiter for a 32-to-1 bit serializer.
// Optional build macro: SER_CTRL_FIXED_PRIO_EN (requester 0 always wins contention).
module ser_ctrl #(
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        ser_rd_en,
  output logic [31:0] ser_word,
  output logic [4:0]  bit_idx,
  output logic        grant_id,
  output logic        word_done,
  output logic        busy
);

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    IDLE  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] ser_word_q;
  logic        grant_q;
  logic [3:0]  gap_cnt;
  logic        accept;
  logic        win;
  logic        rd_en_raw;

  // Mirrors the serializer's own counter: powers up at zero and is never reset.
  logic [4:0]  align_cnt = 5'd0;

  always_comb begin
    state_nxt = state;
    rd_en_raw = 1'b0;
    word_done = 1'b0;
    accept    = 1'b0;
`ifdef SER_CTRL_FIXED_PRIO_EN
    win = req0_valid ? 1'b0 : 1'b1;
`else
    if (req0_valid && req1_valid) begin
      win = ~grant_q;
    end else begin
      win = req0_valid ? 1'b0 : 1'b1;
    end
`endif
    case (state)
      FLUSH: begin
        rd_en_raw = (align_cnt != 5'd0);
        if (align_cnt == 5'd0) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if ((req0_valid || req1_valid) && (align_cnt == 5'd0)) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        rd_en_raw = 1'b1;
        if (align_cnt == 5'd31) begin
          word_done = 1'b1;
          state_nxt = (GAP_CYCLES != 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_cnt <= 4'd1) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = FLUSH;
    endcase
  end

  // Enable must fall the instant reset rises, even mid-word.
  assign ser_rd_en  = rd_en_raw & ~rst;
  assign req0_ready = accept & ~win;
  assign req1_ready = accept & win;
  assign ser_word   = ser_word_q;
  assign bit_idx    = align_cnt;
  assign grant_id   = grant_q;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FLUSH;
      ser_word_q <= 32'd0;
      grant_q    <= 1'b1;
      gap_cnt    <= 4'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ser_word_q <= win ? req1_data : req0_data;
        grant_q    <= win;
      end
      if ((state == SHIFT) && (state_nxt == GAP)) begin
        gap_cnt <= GAP_LOAD;
      end else if ((state == GAP) && (gap_cnt != 4'd0)) begin
        gap_cnt <= gap_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ser_rd_en) begin
      align_cnt <= align_cnt + 5'd1;
    end
  end

endmodule
